// File: rtl/ibex_counter_csr.sv
// Wide CSR performance/cycle counter split across low/high 32-bit CSR words,
// with optional inverted shadow register for fault detection.
module ibex_counter_csr #(
    parameter int unsigned CounterWidth = 64,
    parameter bit          ShadowCopy   = 1'b0,
    parameter logic [63:0] ResetValue   = 64'h0
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        counter_inc_i,
    input  logic        counter_we_i,
    input  logic        counterh_we_i,
    input  logic [31:0] counter_val_i,
    output logic [63:0] counter_val_o,
    output logic [63:0] counter_val_upd_o,
    output logic        overflow_o,
    output logic        err_o
);

    logic [CounterWidth-1:0] counter_q;
    logic [CounterWidth-1:0] counter_d;
    logic [CounterWidth-1:0] counter_inc_s;
    logic [CounterWidth-1:0] counter_load_s;
    logic [63:0]             wdata_s;
    logic [63:0]             wmask_s;
    logic                    write_s;
    logic                    overflow_q;
    logic                    overflow_d;

    assign write_s       = counter_we_i | counterh_we_i;
    assign counter_inc_s = counter_q + CounterWidth'(1'b1);

    // Each write strobe selects its 32-bit half; bits beyond CounterWidth fall away.
    assign wdata_s        = {counter_val_i, counter_val_i};
    assign wmask_s        = {{32{counterh_we_i}}, {32{counter_we_i}}};
    assign counter_load_s = (counter_q & ~wmask_s[CounterWidth-1:0]) |
                            (wdata_s[CounterWidth-1:0] & wmask_s[CounterWidth-1:0]);

    // Next-state selection: writes win over increments and never raise overflow.
    always_comb begin
        counter_d  = counter_q;
        overflow_d = 1'b0;
        if (write_s) begin
            counter_d  = counter_load_s;
            overflow_d = 1'b0;
        end else if (counter_inc_i) begin
            counter_d  = counter_inc_s;
            overflow_d = &counter_q;
        end else begin
            counter_d  = counter_q;
            overflow_d = 1'b0;
        end
    end

    // Counter and overflow pulse registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            counter_q  <= ResetValue[CounterWidth-1:0];
            overflow_q <= 1'b0;
        end else begin
            counter_q  <= counter_d;
            overflow_q <= overflow_d;
        end
    end

    assign counter_val_o     = 64'(counter_q);
    assign counter_val_upd_o = 64'(counter_inc_s);
    assign overflow_o        = overflow_q;

    if (ShadowCopy) begin : g_shadow
        logic [CounterWidth-1:0] shadow_q;

        // Inverted copy tracks every counter update so any single upset shows as a mismatch.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                shadow_q <= ~ResetValue[CounterWidth-1:0];
            end else begin
                shadow_q <= ~counter_d;
            end
        end

        assign err_o = (counter_q != ~shadow_q);
    end else begin : g_no_shadow
        assign err_o = 1'b0;
    end

endmodule
